// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                 if_req;
  logic [ADDR_BITS-1:0] if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [DATA_BITS-1:0] if_rdata;

  logic                 ls_req;
  logic                 ls_we;
  logic [ADDR_BITS-1:0] ls_addr;
  logic [DATA_BITS-1:0] ls_wdata;
  logic                 ls_gnt;
  logic                 ls_rvalid;
  logic [DATA_BITS-1:0] ls_rdata;

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_we;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single synchronous memory port: load/store by
// default, fetch after MAX_WAIT denied cycles; read-valid steered to the issuer.
module mem_bus_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  mem_bus_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  owner_t               rd_owner_reg;
  owner_t               rd_owner_next;
  logic [7:0]           wait_cnt_reg;
  logic [7:0]           wait_cnt_next;
  logic [ADDR_BITS-1:0] addr_hold_reg;

  logic                 fetch_ok;
  logic                 fetch_pri;
  logic                 if_gnt_c;
  logic                 ls_gnt_c;
  logic [ADDR_BITS-1:0] mem_addr_c;

  // Grants are gated by reset so nothing is accepted while the async reset is held.
  always_comb begin
    fetch_ok  = bus.if_req & ~halt;
    fetch_pri = (wait_cnt_reg == MAX_WAIT_C);
    if_gnt_c  = ~reset & fetch_ok & (fetch_pri | ~bus.ls_req);
    ls_gnt_c  = ~reset & bus.ls_req & ~(fetch_ok & fetch_pri);

    if (if_gnt_c) begin
      mem_addr_c = bus.if_addr;
    end else if (ls_gnt_c) begin
      mem_addr_c = bus.ls_addr;
    end else begin
      mem_addr_c = addr_hold_reg;
    end

    if (if_gnt_c) begin
      rd_owner_next = OWN_IF;
    end else if (ls_gnt_c & ~bus.ls_we) begin
      rd_owner_next = OWN_LS;
    end else begin
      rd_owner_next = OWN_NONE;
    end

    if (if_gnt_c | ~bus.if_req | halt) begin
      wait_cnt_next = 8'd0;
    end else if (wait_cnt_reg < MAX_WAIT_C) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end else begin
      wait_cnt_next = wait_cnt_reg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_owner_reg  <= OWN_NONE;
      wait_cnt_reg  <= 8'd0;
      addr_hold_reg <= {ADDR_BITS{1'b0}};
    end else begin
      rd_owner_reg  <= rd_owner_next;
      wait_cnt_reg  <= wait_cnt_next;
      addr_hold_reg <= mem_addr_c;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.ls_gnt    = ls_gnt_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = ls_gnt_c & bus.ls_we;
  assign bus.mem_wdata = reset ? {DATA_BITS{1'b0}} : bus.ls_wdata;

  // Read data is broadcast; each consumer qualifies it with its own rvalid.
  assign bus.if_rvalid = (rd_owner_reg == OWN_IF);
  assign bus.ls_rvalid = (rd_owner_reg == OWN_LS);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, reset corner cases and a
// randomized run, all checked against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset;
  logic halt;

  mem_bus_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_bus_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .MAX_WAIT(MW)) dut (
    .clock (clock),
    .reset (reset),
    .halt  (halt),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Environment memory: registered read, one cycle latency.
  logic [31:0] mem  [0:255];
  logic [31:0] gmem [0:255];

  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  // Model state: consecutive denied fetch cycles, pending read return, last address.
  int          m_denied;
  bit          m_pend_if;
  bit          m_pend_ls;
  logic [31:0] m_pend_data;
  logic [31:0] m_last_addr;

  typedef struct {
    bit          h;
    bit          ir;
    logic [31:0] ia;
    bit          lr;
    bit          lw;
    logic [31:0] la;
    logic [31:0] wd;
    bit          x_if;
    bit          x_ls;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit h, bit ir, logic [31:0] ia, bit lr, bit lw,
                              logic [31:0] la, logic [31:0] wd, bit x_if, bit x_ls);
    vec_t v;
    v.h = h; v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw;
    v.la = la; v.wd = wd; v.x_if = x_if; v.x_ls = x_ls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_denied    = 0;
    m_pend_if   = 1'b0;
    m_pend_ls   = 1'b0;
    m_pend_data = 32'h0;
    m_last_addr = 32'h0;
  endtask

  // Called at posedge+1; drives one cycle, checks, and returns at next posedge+1.
  task automatic cycle(input bit h, input bit ir, input logic [31:0] ia,
                       input bit lr, input bit lw, input logic [31:0] la,
                       input logic [31:0] wd, output bit g_if, output bit g_ls);
    bit          e_if, e_ls, e_we;
    logic [31:0] e_addr;
    halt = h; bus.if_req = ir; bus.if_addr = ia;
    bus.ls_req = lr; bus.ls_we = lw; bus.ls_addr = la; bus.ls_wdata = wd;
    #4;
    e_if   = ir && !h && (!lr || m_denied >= MW);
    e_ls   = lr && !e_if;
    e_we   = e_ls && lw;
    e_addr = e_if ? ia : (e_ls ? la : m_last_addr);
    chk("if_gnt",   32'(bus.if_gnt),    32'(e_if));
    chk("ls_gnt",   32'(bus.ls_gnt),    32'(e_ls));
    chk("mem_we",   32'(bus.mem_we),    32'(e_we));
    chk("mem_addr", bus.mem_addr,       e_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, wd);
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_pend_if));
    chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(m_pend_ls));
    if (m_pend_if) chk("if_rdata", bus.if_rdata, m_pend_data);
    if (m_pend_ls) chk("ls_rdata", bus.ls_rdata, m_pend_data);
    g_if = bus.if_gnt;
    g_ls = bus.ls_gnt;
    @(posedge clock);
    m_pend_if   = e_if;
    m_pend_ls   = e_ls && !lw;
    m_pend_data = gmem[e_addr[7:0]];
    if (e_we) gmem[la[7:0]] = wd;
    m_last_addr = e_addr;
    if (!ir || h || e_if) m_denied = 0;
    else if (m_denied < MW) m_denied++;
    #1;
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      #4;
      chk("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
      chk("rst_ls_gnt",    32'(bus.ls_gnt),    32'd0);
      chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
      chk("rst_mem_addr",  bus.mem_addr,       32'd0);
      chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit          g_if, g_ls;
    bit          ir, lr, lw, h;
    logic [31:0] ia, la, wd;

    for (int i = 0; i < 256; i++) begin
      mem[i]  <= 32'hA5A5_0000 ^ (i * 32'h0101_0137);
      gmem[i]  = 32'hA5A5_0000 ^ (i * 32'h0101_0137);
    end
    reset = 1'b1; halt = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd5;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'd0;
    bus.ls_wdata = 32'hFFFF_FFFF;
    model_reset();
    @(posedge clock);
    #1;

    // Reset held ~100 ticks with fetch requesting, then first fetch right after release.
    hold_reset(10);
    cycle(0, 1, 32'd5, 0, 0, 0, 0, g_if, g_ls);
    cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_ls);

    // Directed table.
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, k, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h10, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 1, 32'h40, 1, 0, 32'h80, 0, (k % 5) == 4, (k % 5) != 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h44, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 32'h45, 1, 0, 32'h81, 0, 0, 1));
    tbl.push_back(mk(1, 1, 32'h45, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 1, 32'h45, 1, 0, 32'h82, 0, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, 32'h45, 1, 0, 32'h83, 0, k == 4, k != 4));
    tbl.push_back(mk(1, 1, 32'h47, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h47, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    hold_reset(1);
    foreach (tbl[i]) begin
      cycle(tbl[i].h, tbl[i].ir, tbl[i].ia, tbl[i].lr, tbl[i].lw,
            tbl[i].la, tbl[i].wd, g_if, g_ls);
      chk($sformatf("tbl%0d_if_gnt", i), 32'(g_if), 32'(tbl[i].x_if));
      chk($sformatf("tbl%0d_ls_gnt", i), 32'(g_ls), 32'(tbl[i].x_ls));
    end

    // Reset right after a load grant: its rvalid must never appear.
    cycle(0, 0, 0, 1, 0, 32'h20, 0, g_if, g_ls);
    hold_reset(2);
    cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_ls);
    cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_ls);

    // Randomized traffic; requesters hold their request until granted.
    ir = 0; lr = 0; lw = 0; ia = 0; la = 0; wd = 0;
    for (int n = 0; n < 400; n++) begin
      h = ($urandom_range(0, 5) == 0);
      if (!ir) begin
        ir = ($urandom_range(0, 99) < 70);
        ia = 32'($urandom_range(0, 255));
      end
      if (!lr) begin
        lr = ($urandom_range(0, 99) < 60);
        lw = ($urandom_range(0, 2) == 0);
        la = 32'($urandom_range(0, 255));
        wd = $urandom;
      end
      cycle(h, ir, ia, lr, lw, la, wd, g_if, g_ls);
      if (g_if) ir = 0;
      if (g_ls) lr = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_ls);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single synchronous memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Grants at most one request per cycle.
- Memory returns read data one cycle after the address is presented; the arbiter steers a read-valid strobe back to the requester that issued the read.
- Load/store has default priority; a starvation counter guarantees fetch forward progress. Fetch grants stop when the core halts.

Parameters:
DATA_BITS, 32, width of the memory data bus
ADDR_BITS, 32, width of the memory address bus
MAX_WAIT, 4, cycles fetch may be denied before it takes priority; legal range 1..255

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
halt  input  1  core halted; blocks new fetch grants
if_req  input  1  fetch read request
if_addr  input  ADDR_BITS  fetch address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  if_rdata valid
if_rdata  output  DATA_BITS  fetch read data
ls_req  input  1  load/store request
ls_we  input  1  1 = write, 0 = read
ls_addr  input  ADDR_BITS  load/store address
ls_wdata  input  DATA_BITS  store data
ls_gnt  output  1  load/store request accepted this cycle
ls_rvalid  output  1  ls_rdata valid (loads only)
ls_rdata  output  DATA_BITS  load read data
mem_addr  output  ADDR_BITS  memory address
mem_we  output  1  memory write enable
mem_wdata  output  DATA_BITS  memory write data
mem_rdata  input  DATA_BITS  memory read data, registered inside memory, valid one cycle after mem_addr

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock.
  - While reset=1: if_gnt=0, ls_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rvalid=0, ls_rvalid=0, wait_cnt=0, rd_owner=NONE.
  - Reset mid-transaction drops the pending rvalid; it is never issued after reset deasserts.
- Grant logic (combinational from the current req inputs and the registered wait_cnt):
  - fetch_ok = if_req & ~halt.
  - Fetch priority when wait_cnt == MAX_WAIT; otherwise load/store priority.
  - Exactly one of if_gnt and ls_gnt may be 1; both are 0 if no eligible request.
  - Requesters hold req/addr/wdata stable until granted; the arbiter never grants a deasserted req.
- Memory drive:
  - Granted requester's addr drives mem_addr.
  - mem_we = ls_gnt & ls_we; mem_wdata = ls_wdata.
  - Idle cycle: mem_addr holds its previous value (registered copy) and mem_we=0.
- Read return:
  - Registered rd_owner ∈ {NONE, IF, LS}, set at each edge from the current grant: IF if if_gnt, LS if ls_gnt & ~ls_we, else NONE.
  - if_rvalid = (rd_owner==IF); ls_rvalid = (rd_owner==LS).
  - Fixed latency: rvalid one cycle after gnt.
  - if_rdata = ls_rdata = mem_rdata, broadcast; consumers qualify with rvalid.
  - Writes produce no rvalid.
  - Back-to-back grants are allowed every cycle, giving full throughput.
- Starvation counter wait_cnt, width 8, registered:
  - if_gnt=1 or if_req=0 or halt=1 → 0.
  - Else if fetch_ok & ~if_gnt → saturating increment to MAX_WAIT.
  - At MAX_WAIT fetch wins the next arbitration; the counter then clears, so load/store starves at most 1 cycle per MAX_WAIT+1.
- Halt:
  - Affects only fetch; outstanding fetch rvalid is still delivered.
  - Load/store continues to be served.
  - Halt deasserting re-enables fetch the same cycle.
- Simultaneous requests, wait_cnt < MAX_WAIT: ls wins and wait_cnt increments.

Test Plan:
1. Reset held 100 ticks with if_req=1 → all gnt/rvalid/mem_we=0 throughout. First edge after release: if_gnt=1, mem_addr=if_addr; next cycle if_rvalid=1, if_rdata=mem[if_addr].
2. Fetch only, addresses 0,1,2,3 on consecutive cycles → if_gnt=1 every cycle. if_rvalid high from cycle 2 onward with data mem[0..3] in order.
3. Both requesting continuously, ls_we=0, MAX_WAIT=4 → grant pattern LS,LS,LS,LS,IF repeating. ls_rvalid/if_rvalid follow the same pattern delayed one cycle, never both high.
4. ls_req=1, ls_we=1, ls_addr=0x10, ls_wdata=0xDEADBEEF → ls_gnt=1, mem_we=1 for one cycle, no ls_rvalid. A later load of 0x10 returns 0xDEADBEEF with ls_rvalid one cycle after grant.
5. Fetch granted at cycle N, halt=1 at N+1 with if_req=1 → if_rvalid=1 at N+1, if_gnt=0 and wait_cnt=0 while halted, ls requests still granted. Halt=0 → if_gnt=1 that cycle.
6. Reset asserted the cycle after an LS read grant → ls_rvalid stays 0 and is not emitted after release.
